fp_div_arbiter: RTL and testbench
=================================

FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one pipelined single-precision divider.
REQ-002 Parameter LATENCY, default 8: divider cycles from operand launch to result.
REQ-003 Clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_a  input  NREQ*32  dividends; requester i occupies bits [32i+31:32i].
REQ-007 req_b  input  NREQ*32  divisors; same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 rsp_valid  output  NREQ  per-requester result available.
REQ-010 rsp_data  output  NREQ*32  per-requester quotient; same packing as req_a.
REQ-011 rsp_ready  input  NREQ  per-requester result consume strobe.
REQ-012 div_a, div_b  output  32 each  registered operands to the divider.
REQ-013 div_in_valid  output  1  high in the cycle div_a/div_b carry a launched operation.
REQ-014 div_result  input  32  divider output, valid LATENCY cycles after the launch cycle.
REQ-015 busy  output  NREQ  registered outstanding flag per requester.

Function
REQ-016 Each requester SHALL have at most one outstanding operation: busy[i] sets on accept and clears on the rsp_valid[i] & rsp_ready[i] handshake.
REQ-017 Eligibility: req_valid[i] & ~busy[i].
REQ-018 Arbitration: round-robin; the search starts at index ptr and wraps modulo NREQ; the first eligible index is granted.
REQ-019 req_ready SHALL be combinational and at most one-hot; it is all-zero when no requester is eligible.
REQ-020 On accept of index g, ptr SHALL update to (g+1) mod NREQ; ptr SHALL hold when there is no accept.
REQ-021 On accept, div_a/div_b SHALL register req_a/req_b slice g, and div_in_valid SHALL be high in the next cycle (launch cycle T).
REQ-022 div_in_valid SHALL be low in any cycle following a cycle with no accept; div_a/div_b hold their last values.
REQ-023 A tag pipeline of depth LATENCY SHALL carry (valid, id) alongside each launch.
REQ-024 When a valid tag with id k exits at cycle T+LATENCY, rsp_data[k] SHALL register div_result and rsp_valid[k] SHALL assert in cycle T+LATENCY+1.
REQ-025 Accept-to-rsp_valid latency SHALL be exactly LATENCY+2 cycles.
REQ-026 rsp_valid[k] and rsp_data[k] SHALL hold until the rsp_ready[k] handshake; rsp_valid[k] deasserts in the following cycle.
REQ-027 Responses SHALL never collide, because the one-outstanding rule prevents it; no response buffering beyond one entry per requester.
REQ-028 Sustained throughput SHALL be one accept per cycle when distinct requesters are eligible.
REQ-029 A requester whose response is consumed in cycle C SHALL not be granted before cycle C+1, because busy is registered.
REQ-030 rsp_ready[i] SHALL be ignored while rsp_valid[i] is low.
REQ-031 Quotient values come solely from div_result; the block performs no arithmetic on them.

Reset
REQ-032 While Rst is low at the clock edge: ptr=0, busy=0, rsp_valid=0, rsp_data=0, div_a=0, div_b=0, div_in_valid=0, and all tag valids =0.
REQ-033 Reset mid-operation SHALL discard in-flight tags; later div_result values SHALL be ignored and no rsp_valid SHALL assert for them.
REQ-034 req_ready SHALL be 0 while Rst is low.

Verification
REQ-035 Single op: req0 a=0x40C00000, b=0x40000000 -> rsp_valid[0] exactly LATENCY+2 cycles after accept with rsp_data[0]=0x40400000; busy[0] clears after the rsp_ready handshake.
REQ-036 All four requesters valid continuously from reset -> grants in order 0,1,2,3 on consecutive cycles; div_in_valid high for 4 consecutive cycles; no further grants until responses are consumed.
REQ-037 Fairness: after granting 2, with 1 and 3 eligible -> 3 is granted before 1.
REQ-038 Back-pressure: req1 a=0x3F800000, b=0x40800000 with rsp_ready[1]=0 for 20 cycles -> rsp_data[1]=0x3E800000 held stable, req_ready[1]=0 throughout, and other requesters are still served.
REQ-039 Reset pulsed 3 cycles after an accept -> no rsp_valid is ever produced for that op; all outputs are at reset values.
REQ-040 Consume-and-reissue: rsp_ready[2] and req_valid[2] both high in cycle C -> req_ready[2]=0 in C and grant no earlier than C+1.

Source files
------------

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one pipelined single-precision divider among NREQ requesters.
// One outstanding op per requester; a tag pipeline steers each quotient into a per-requester slot.
module fp_div_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ*32-1:0]   rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  output logic                 div_in_valid,
  input  logic [31:0]          div_result,
  output logic [NREQ-1:0]      busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   div_id;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rsp_done;
  logic [NREQ-1:0] exit_mask;
  logic            found;
  logic            accept;
  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]   tag_id [LATENCY];

  assign eligible = req_valid & ~busy;
  assign rsp_done = rsp_valid & rsp_ready;

  // Search from ptr upward, wrapping; first eligible requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      cand = IW'((32'(ptr) + o) % NREQ);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        gnt_idx     = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign accept    = found & Rst;
  assign req_ready = grant & {NREQ{Rst}};

  always_comb begin
    exit_mask = '0;
    if (tag_v[LATENCY-1]) exit_mask[tag_id[LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ptr          <= '0;
      busy         <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      div_a        <= '0;
      div_b        <= '0;
      div_in_valid <= 1'b0;
      div_id       <= '0;
      tag_v        <= '0;
      for (int unsigned j = 0; j < LATENCY; j++) tag_id[j] <= '0;
    end else begin
      div_in_valid <= accept;
      if (accept) begin
        div_a  <= req_a[32*gnt_idx +: 32];
        div_b  <= req_b[32*gnt_idx +: 32];
        div_id <= gnt_idx;
        ptr    <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      busy <= (busy | (accept ? grant : '0)) & ~rsp_done;

      // Tag stage 0 captures the launch cycle, so the last stage lines up with div_result.
      tag_v[0]  <= div_in_valid;
      tag_id[0] <= div_id;
      for (int unsigned j = 1; j < LATENCY; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end

      rsp_valid <= (rsp_valid & ~rsp_done) | exit_mask;
      if (tag_v[LATENCY-1]) rsp_data[32*tag_id[LATENCY-1] +: 32] <= div_result;
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a table-driven pipelined divider model.
module tb_fp_div_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 8;

  logic               clk = 1'b0;
  logic               Rst;
  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [NREQ*32-1:0] req_a, req_b, rsp_data;
  logic [31:0]        div_a, div_b, div_result;
  logic               div_in_valid;
  logic [31:0]        pipe [LAT];
  int errors = 0;
  int checks = 0;

  fp_div_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .Clk(clk), .Rst(Rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .div_a(div_a), .div_b(div_b), .div_in_valid(div_in_valid), .div_result(div_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000; // 6/2
      {32'h3F800000, 32'h40800000}: return 32'h3E800000; // 1/4
      {32'h41000000, 32'h40000000}: return 32'h40800000; // 8/2
      {32'h3F800000, 32'h40000000}: return 32'h3F000000; // 1/2
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    pipe[0] <= div_in_valid ? fdiv(div_a, div_b) : 32'h0BADF00D;
    for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign div_result = pipe[LAT-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset;
    Rst = 1'b0; req_valid = '1; rsp_ready = '0;
    set_op(0, 32'h40C00000, 32'h40000000);
    tick; tick;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if ({div_in_valid, div_a, div_b} !== 65'd0) begin errors++; $display("FAIL reset_div: got %b %h %h expected 0 0 0", div_in_valid, div_a, div_b); end
    req_valid = '0; Rst = 1'b1;
    tick;
  endtask

  task automatic test_single;
    int cnt;
    set_op(0, 32'h40C00000, 32'h40000000);
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick; req_valid = '0;
    checks++; if (div_in_valid !== 1'b1 || div_a !== 32'h40C00000 || div_b !== 32'h40000000) begin errors++; $display("FAIL single_launch: got %b %h %h expected 1 40c00000 40000000", div_in_valid, div_a, div_b); end
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL single_busy: got %b expected 0001", busy); end
    cnt = 1;
    while (!rsp_valid[0] && cnt < 30) begin tick; cnt++; end
    checks++; if (cnt != LAT + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", cnt, LAT + 2); end
    checks++; if (rsp_data[31:0] !== 32'h40400000) begin errors++; $display("FAIL single_data: got %h expected 40400000", rsp_data[31:0]); end
    rsp_ready = 4'b0001; tick; rsp_ready = '0;
    checks++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL single_release: got rsp_valid=%b busy=%b expected 0 0", rsp_valid[0], busy[0]); end
  endtask

  task automatic test_all_four;
    logic [31:0] ea [4];
    logic [31:0] eb [4];
    logic [31:0] eq [4];
    ea = '{32'h40C00000, 32'h3F800000, 32'h41000000, 32'h3F800000};
    eb = '{32'h40000000, 32'h40800000, 32'h40000000, 32'h40000000};
    eq = '{32'h40400000, 32'h3E800000, 32'h40800000, 32'h3F000000};
    Rst = 1'b0; tick;
    for (int i = 0; i < 4; i++) set_op(i, ea[i], eb[i]);
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL four_ready_in_reset: got %b expected 0000", req_ready); end
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << i)) begin errors++; $display("FAIL four_grant%0d: got %b expected %b", i, req_ready, 4'b0001 << i); end
      tick;
      checks++; if (div_in_valid !== 1'b1 || div_a !== ea[i] || div_b !== eb[i]) begin errors++; $display("FAIL four_launch%0d: got %b %h %h expected 1 %h %h", i, div_in_valid, div_a, div_b, ea[i], eb[i]); end
    end
    checks++; if (req_ready !== 4'b0000 || busy !== 4'b1111) begin errors++; $display("FAIL four_saturated: got ready=%b busy=%b expected 0000 1111", req_ready, busy); end
    tick;
    checks++; if (div_in_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL four_idle: got div_in_valid=%b ready=%b expected 0 0000", div_in_valid, req_ready); end
    req_valid = '0;
    for (int k = 0; k < 30 && rsp_valid !== 4'b1111; k++) tick;
    checks++; if (rsp_valid !== 4'b1111) begin errors++; $display("FAIL four_rsp_valid: got %b expected 1111", rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_data[32*i +: 32] !== eq[i]) begin errors++; $display("FAIL four_data%0d: got %h expected %h", i, rsp_data[32*i +: 32], eq[i]); end
    end
    rsp_ready = 4'b1111; tick; rsp_ready = '0;
    checks++; if (rsp_valid !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("FAIL four_drain: got rsp_valid=%b busy=%b expected 0000 0000", rsp_valid, busy); end
  endtask

  task automatic test_fairness;
    set_op(1, 32'h3F800000, 32'h40800000);
    set_op(2, 32'h41000000, 32'h40000000);
    set_op(3, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_grant2: got %b expected 0100", req_ready); end
    tick; req_valid = 4'b1110; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL fair_grant3: got %b expected 1000", req_ready); end
    tick;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_grant1: got %b expected 0010", req_ready); end
    tick; req_valid = '0;
    for (int k = 0; k < 30 && rsp_valid !== 4'b1110; k++) tick;
    checks++; if (rsp_valid !== 4'b1110 || rsp_data[127:32] !== {32'h3F000000, 32'h40800000, 32'h3E800000}) begin errors++; $display("FAIL fair_rsp: got %b %h expected 1110 3f000000408000003e800000", rsp_valid, rsp_data[127:32]); end
    rsp_ready = 4'b1110; tick; rsp_ready = '0;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL fair_drain: got %b expected 0000", busy); end
  endtask

  task automatic test_backpressure;
    set_op(1, 32'h3F800000, 32'h40800000);
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b expected 0010", req_ready); end
    tick; req_valid = '0;
    for (int k = 0; k < 30 && !rsp_valid[1]; k++) tick;
    set_op(0, 32'h41000000, 32'h40000000);
    req_valid = 4'b0011; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b expected 0001", req_ready); end
    for (int k = 0; k < 20; k++) begin
      checks++; if (rsp_valid[1] !== 1'b1 || rsp_data[63:32] !== 32'h3E800000 || req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h ready=%b expected 1 3e800000 0", k, rsp_valid[1], rsp_data[63:32], req_ready[1]); end
      tick;
    end
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== 32'h40800000) begin errors++; $display("FAIL bp_other_served: got %b %h expected 1 40800000", rsp_valid[0], rsp_data[31:0]); end
    req_valid = '0; rsp_ready = 4'b0011; tick; rsp_ready = '0;
    checks++; if (rsp_valid !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("FAIL bp_drain: got rsp_valid=%b busy=%b expected 0000 0000", rsp_valid, busy); end
  endtask

  task automatic test_consume_reissue;
    set_op(2, 32'h41000000, 32'h40000000);
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL cr_first_grant: got %b expected 0100", req_ready); end
    tick; req_valid = '0;
    for (int k = 0; k < 30 && !rsp_valid[2]; k++) tick;
    checks++; if (rsp_valid[2] !== 1'b1 || rsp_data[95:64] !== 32'h40800000) begin errors++; $display("FAIL cr_rsp: got %b %h expected 1 40800000", rsp_valid[2], rsp_data[95:64]); end
    rsp_ready = 4'b0100; req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL cr_no_grant_in_c: got %b expected 0000", req_ready); end
    tick; rsp_ready = '0; #1;
    checks++; if (rsp_valid[2] !== 1'b0 || busy[2] !== 1'b0 || req_ready !== 4'b0100) begin errors++; $display("FAIL cr_regrant: got valid=%b busy=%b ready=%b expected 0 0 0100", rsp_valid[2], busy[2], req_ready); end
    tick; req_valid = '0;
    checks++; if (busy !== 4'b0100 || div_in_valid !== 1'b1 || div_a !== 32'h41000000) begin errors++; $display("FAIL cr_relaunch: got busy=%b v=%b a=%h expected 0100 1 41000000", busy, div_in_valid, div_a); end
    for (int k = 0; k < 30 && !rsp_valid[2]; k++) tick;
    rsp_ready = 4'b0100; tick; rsp_ready = '0;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL cr_drain: got %b expected 0000", busy); end
  endtask

  task automatic test_reset_midop;
    set_op(0, 32'h40C00000, 32'h40000000);
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_grant: got %b expected 0001", req_ready); end
    tick; req_valid = '0;
    tick; tick;
    Rst = 1'b0; req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready_low: got %b expected 0000", req_ready); end
    tick; req_valid = '0; Rst = 1'b1;
    checks++; if (busy !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_data !== '0) begin errors++; $display("FAIL rst_state: got busy=%b valid=%b data=%h expected 0", busy, rsp_valid, rsp_data); end
    checks++; if ({div_in_valid, div_a, div_b} !== 65'd0) begin errors++; $display("FAIL rst_div: got %b %h %h expected 0 0 0", div_in_valid, div_a, div_b); end
    for (int k = 0; k < 20; k++) begin
      tick;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_no_rsp%0d: got %b expected 0000", k, rsp_valid); end
    end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr: got %b expected 0001", req_ready); end
    req_valid = '0;
    tick;
  endtask

  initial begin
    Rst = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    test_reset;
    test_single;
    test_all_four;
    test_fairness;
    test_backpressure;
    test_consume_reissue;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
